// File: rtl/alu_pkg.sv
// Shared types and the single-cycle ALU function for seq_alu.
// alu_simple works on MAX_W-bit words: callers zero-extend operands and truncate the result.
package alu_pkg;

    localparam int MAX_W = 64;

    typedef logic [MAX_W-1:0] word_t;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_LUI   = 4'd5,
        OP_SLT   = 4'd6,
        OP_SLTU  = 4'd7,
        OP_SLL   = 4'd8,
        OP_SRL   = 4'd9,
        OP_SRA   = 4'd10,
        OP_MULT  = 4'd11,
        OP_MULTU = 4'd12,
        OP_DIV   = 4'd13,
        OP_DIVU  = 4'd14
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } state_e;

    function automatic logic is_muldiv(op_e op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    endfunction

    function automatic logic is_div(op_e op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    function automatic logic is_signed_op(op_e op);
        return op inside {OP_MULT, OP_DIV};
    endfunction

    // Sign-extend a width-bit value held in a zero-extended word.
    function automatic word_t sext(word_t v, int width);
        word_t mask;
        mask = ~((word_t'(1) << width) - word_t'(1));
        return v[6'(width - 1)] ? (v | mask) : v;
    endfunction

    function automatic word_t alu_simple(op_e op, word_t a, word_t b, logic [5:0] shamt,
                                         int width, int lui_shift);
        word_t r;
        r = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_LUI:  r = b << lui_shift;
            OP_SLT:  r[0] = $signed(sext(a, width)) < $signed(sext(b, width));
            OP_SLTU: r[0] = a < b;
            OP_SLL:  r = a << shamt;
            OP_SRL:  r = a >> shamt;
            OP_SRA:  r = $signed(sext(a, width)) >>> shamt;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the issue stage and seq_alu.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    import alu_pkg::*;

    logic             start;
    logic             ready;
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             done;

    modport master (
        output start, op, a, b,
        input  ready, result, zero, hi, lo, done
    );

    modport slave (
        input  start, op, a, b,
        output ready, result, zero, hi, lo, done
    );

endinterface

// File: rtl/seq_muldiv.sv
// Iterative multiply/divide engine: one bit per cycle over a shared acc/sr shift pair,
// magnitudes on entry and sign fix-up in a final FIX cycle.
module seq_muldiv
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             idle,
    output logic             fin,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e state_q, state_d;

    logic [WIDTH-1:0]   acc_q, sr_q, mcand_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_lo_q, neg_hi_q, div_q, bzero_q;
    logic               last;
    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, rem_sh;
    logic               q_bit;
    logic [2*WIDTH-1:0] prod;

    assign last = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        sa    = is_signed_op(op) && a[WIDTH-1];
        sb    = is_signed_op(op) && b[WIDTH-1];
        mag_a = sa ? -a : a;
        mag_b = sb ? -b : b;
    end

    // acc:sr is the product during MUL, remainder:quotient during DIV.
    always_comb begin
        mul_sum = {1'b0, acc_q} + (sr_q[0] ? {1'b0, mcand_q} : '0);
        rem_sh  = {acc_q, sr_q[WIDTH-1]};
        q_bit   = (rem_sh >= {1'b0, mcand_q});
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, otherwise synthesis infers latches.
    always_comb begin
        state_d = state_q;
        idle    = 1'b0;
        fin     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idle = 1'b1;
                if (start) state_d = is_div(op) ? ST_DIV : ST_MUL;
            end
            ST_MUL, ST_DIV: begin
                if (last) state_d = ST_FIX;
            end
            ST_FIX: begin
                fin     = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: datapath flops are reset as well so an aborted op can never leak X into hi/lo.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            sr_q     <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div_q    <= 1'b0;
            bzero_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        div_q    <= is_div(op);
                        neg_lo_q <= sa ^ sb;
                        neg_hi_q <= sa;
                        bzero_q  <= (b == '0);
                        sr_q     <= is_div(op) ? mag_a : mag_b;
                        mcand_q  <= is_div(op) ? mag_b : mag_a;
                    end
                end
                ST_MUL: begin
                    acc_q <= mul_sum[WIDTH:1];
                    sr_q  <= {mul_sum[0], sr_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + 1'b1;
                end
                ST_DIV: begin
                    acc_q <= q_bit ? WIDTH'(rem_sh - {1'b0, mcand_q}) : rem_sh[WIDTH-1:0];
                    sr_q  <= {sr_q[WIDTH-2:0], q_bit};
                    cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // With a zero divisor every step "subtracts" nothing, so acc ends holding |a|
    // and the normal remainder sign fix already yields hi = a.
    always_comb begin
        prod = {acc_q, sr_q};
        if (neg_lo_q) prod = -prod;
        hi = prod[2*WIDTH-1:WIDTH];
        lo = prod[WIDTH-1:0];
        if (div_q) begin
            hi = neg_hi_q ? -acc_q : acc_q;
            lo = bzero_q ? '1 : (neg_lo_q ? -sr_q : sr_q);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ops answer one cycle after accept, mul/div run through
// seq_muldiv; result/zero/hi/lo are registered and held until the next done.
module seq_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int LUI_SHIFT = WIDTH / 2,
    localparam int CNT_W     = $clog2(WIDTH) + 1
) (
    input  logic clk,
    input  logic rst,
    seq_alu_if.slave bus
);

    logic             ready;
    logic             accept;
    logic             md_start;
    logic             md_fin;
    logic [WIDTH-1:0] simple_res;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic [WIDTH-1:0] result_q, hi_q, lo_q;
    logic             zero_q, done_q;

    assign accept   = bus.start && ready;
    assign md_start = accept && is_muldiv(bus.op);

    // Shift amount uses only the low log2(WIDTH) bits of b.
    assign simple_res = WIDTH'(alu_simple(bus.op, word_t'(bus.a), word_t'(bus.b),
                                          6'(bus.b[CNT_W-2:0]), WIDTH, LUI_SHIFT));

    seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (md_start),
        .op    (bus.op),
        .a     (bus.a),
        .b     (bus.b),
        .idle  (ready),
        .fin   (md_fin),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (md_fin) begin
                hi_q     <= md_hi;
                lo_q     <= md_lo;
                result_q <= md_lo;
                zero_q   <= (md_lo == '0);
                done_q   <= 1'b1;
            end else if (accept && !is_muldiv(bus.op)) begin
                result_q <= simple_res;
                zero_q   <= (simple_res == '0);
                done_q   <= 1'b1;
            end
        end
    end

    assign bus.ready  = ready;
    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: a 32-bit instance for the bulk of the vectors
// and an 8-bit instance for the narrow-width multiply.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    seq_alu_if #(.WIDTH(W)) bus ();
    seq_alu_if #(.WIDTH(8)) bus8 ();

    seq_alu #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_simple(input string tag, input op_e op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] exp);
        @(negedge clk);
        check({tag, " ready"}, 64'(bus.ready), 64'd1);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, " done"}, 64'(bus.done), 64'd1);
        check({tag, " result"}, 64'(bus.result), 64'(exp));
        check({tag, " zero"}, 64'(bus.zero), 64'(exp == '0));
    endtask

    // Edges are counted with the accept edge as edge 1.
    task automatic run_md(input string tag, input op_e op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input bit poke);
        int edges;
        int busy;
        @(negedge clk);
        check({tag, " ready"}, 64'(bus.ready), 64'd1);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        edges = 1;
        busy  = bus.ready ? 0 : 1;
        while (!bus.done && edges < 100) begin
            if (poke && (edges == 5 || edges == 20)) begin
                bus.start = 1'b1;
                bus.op    = OP_ADD;
                bus.a     = 32'd1;
                bus.b     = 32'd1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
            if (!bus.ready && !bus.done) busy++;
        end
        bus.start = 1'b0;
        check({tag, " edges"}, 64'(edges), 64'(W + 2));
        check({tag, " busy"}, 64'(busy), 64'(W + 1));
        check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
        check({tag, " result"}, 64'(bus.result), 64'(exp_lo));
        check({tag, " zero"}, 64'(bus.zero), 64'(exp_lo == '0));
        check({tag, " ready"}, 64'(bus.ready), 64'd1);
    endtask

    initial begin
        int edges8;
        int done_seen;
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.op     = OP_ADD;
        bus.a      = '0;
        bus.b      = '0;
        bus8.start = 1'b0;
        bus8.op    = OP_ADD;
        bus8.a     = '0;
        bus8.b     = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst result", 64'(bus.result), 64'd0);
        check("rst zero", 64'(bus.zero), 64'd1);
        check("rst hi", 64'(bus.hi), 64'd0);
        check("rst lo", 64'(bus.lo), 64'd0);
        check("rst done", 64'(bus.done), 64'd0);
        check("rst ready", 64'(bus.ready), 64'd1);
        #1 rst = 1'b0;

        // Single-cycle ops, back to back.
        run_simple("add ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
        run_simple("sub 5-5", OP_SUB, 32'd5, 32'd5, 32'd0);
        run_simple("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        run_simple("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_simple("sra", OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
        run_simple("srl", OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
        run_simple("lui", OP_LUI, 32'd0, 32'h1234, 32'h1234_0000);
        run_simple("sll masked", OP_SLL, 32'd1, 32'h25, 32'h20);
        run_simple("and", OP_AND, 32'hF0F0, 32'hFF00, 32'hF000);
        run_simple("or", OP_OR, 32'hF0F0, 32'hFF00, 32'hFFF0);
        run_simple("xor", OP_XOR, 32'hF0F0, 32'hFF00, 32'h0FF0);
        run_simple("undef op", op_e'(4'hF), 32'd1, 32'd1, 32'd0);

        // Signed multiply with start pulses while busy.
        run_md("mult -3*7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
        run_simple("xor after mult", OP_XOR, 32'h1, 32'h3, 32'h2);
        check("hi held", 64'(bus.hi), 64'hFFFF_FFFF);
        check("lo held", 64'(bus.lo), 64'hFFFF_FFEB);

        // Divides.
        run_md("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_md("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_md("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        run_md("divu 3/7", OP_DIVU, 32'd3, 32'd7, 32'd3, 32'd0, 1'b0);
        run_md("div 5/0", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);

        // Reset ten cycles into a divide: outputs clear without a clock edge.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst result", 64'(bus.result), 64'd0);
        check("midrst zero", 64'(bus.zero), 64'd1);
        check("midrst hi", 64'(bus.hi), 64'd0);
        check("midrst lo", 64'(bus.lo), 64'd0);
        check("midrst done", 64'(bus.done), 64'd0);
        check("midrst ready", 64'(bus.ready), 64'd1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        done_seen = 0;
        repeat (W + 8) begin
            @(posedge clk);
            #1;
            if (bus.done) done_seen++;
        end
        check("midrst no done", 64'(done_seen), 64'd0);
        run_simple("add after rst", OP_ADD, 32'd2, 32'd3, 32'd5);

        // ADD followed by MULTU on the edge ending the ADD's done cycle.
        run_simple("add b2b", OP_ADD, 32'd1, 32'd1, 32'd2);
        run_md("multu b2b", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 1'b0);
        @(posedge clk);
        #1;
        check("done pulse", 64'(bus.done), 64'd0);

        // Narrow build: 8-bit unsigned multiply.
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.op    = OP_MULTU;
        bus8.a     = 8'hFF;
        bus8.b     = 8'hFF;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        edges8 = 1;
        while (!bus8.done && edges8 < 100) begin
            @(posedge clk);
            #1;
            edges8++;
        end
        check("w8 edges", 64'(edges8), 64'd10);
        check("w8 hi", 64'(bus8.hi), 64'hFE);
        check("w8 lo", 64'(bus8.lo), 64'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised multi-cycle successor to the single-cycle ALU in the CPU datapath.
- Keeps all single-cycle ops and adds shifts, unsigned compare, iterative multiply and divide, with HI/LO result registers.
- Uses a start/ready/done handshake so the multi-cycle controller can stall while mul/div runs.
- Sits between the register-file read stage and writeback.

Parameters:
- WIDTH, 32, operand/result width; even, at least 4.
- LUI_SHIFT, WIDTH/2, left-shift amount for the LUI op.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request; accepted only when ready=1.
- ready  out  1  high when idle and able to accept.
- op  in  4  operation code (package enum).
- a  in  WIDTH  operand A; captured on accept.
- b  in  WIDTH  operand B; captured on accept.
- result  out  WIDTH  registered result; holds until the next done.
- zero  out  1  result==0; registered alongside result.
- hi  out  WIDTH  mul: upper half of product; div: remainder.
- lo  out  WIDTH  mul: lower half of product; div: quotient.
- done  out  1  one-cycle pulse when result, hi and lo are valid.

Behaviour:
- Reset (asynchronous, active-high, any time including mid-operation):
  - State goes to IDLE; any in-flight op is aborted with no done.
  - result=0, zero=1, hi=0, lo=0, done=0, ready=1.
  - After rst drops, the first accept can happen on the next clk edge.
- Accept: start and ready both high at a rising edge. a, b and op are latched at that edge; later input changes are ignored. start while ready=0 is dropped, not queued.
- Single-cycle ops:
  - ADD, SUB, AND, OR, XOR: modular WIDTH-bit; no overflow flag.
  - LUI: b<<LUI_SHIFT.
  - SLT: signed a<b gives 1, else 0.
  - SLTU: unsigned a<b gives 1, else 0.
  - SLL, SRL, SRA: shift a by b[CNT_W-2:0]; SRA sign-fills.
  - Result registered at the accept edge, so done is high in the next cycle (latency 1).
  - ready stays 1, so back-to-back accepts give done every cycle.
  - hi and lo are unchanged.
- Undefined op codes: result=0, zero=1, done after latency 1. No X may propagate.
- State machine: IDLE, MUL, DIV, FIX.
  - IDLE: a simple op stays in IDLE. MULT/MULTU goes to MUL and DIV/DIVU goes to DIV; in both cases ready drops, cnt=0, and operand magnitudes are latched (signed ops take abs values and record signs).
  - MUL: shift-add, one multiplier bit per cycle. After WIDTH cycles, go to FIX.
  - DIV: restoring division, one quotient bit per cycle. After WIDTH cycles, go to FIX.
  - FIX: apply signs, write hi/lo and result=lo, pulse done, return to IDLE. ready returns to 1 in the same cycle as done, so the next accept is allowed at the edge ending the done cycle.
- Mul/div latency: WIDTH+2 edges from the accept edge to done-high. ready is low for WIDTH+1 cycles.
- Signed multiply: the 2*WIDTH product is negated if sign(a)^sign(b).
- Signed divide:
  - Quotient is negated if sign(a)^sign(b); remainder takes the sign of a.
  - MIN/-1 gives quotient=MIN, remainder=0.
- Divide by zero (signed or unsigned):
  - lo=all ones, hi=a.
  - Full latency still applies; the iteration runs, then the output is forced in FIX.
- zero is always computed from the value written to result.

Decomposition:
- Shared package alu_pkg:
  - op enum: ADD, SUB, AND, OR, XOR, LUI, SLT, SLTU, SLL, SRL, SRA, MULT, MULTU, DIV, DIVU.
  - state enum.
  - Helper function for the combinational single-cycle result, reusable by the single-cycle core.
- One sub-module, seq_muldiv: shared WIDTH-iteration shift register and counter, covering MUL, DIV and FIX.
- seq_alu holds the combinational ops, the handshake and the output registers.

Test Plan:
- Reset and simple ops: rst pulse, then ADD a=0x7FFFFFFF b=1 → result 0x80000000 and done the next cycle. Then SUB 5-5 → result 0, zero=1. Then SLT a=0xFFFFFFFF b=1 → 1, and SLTU with the same operands → 0.
- Shifts and LUI: SRA a=0x80000000 b=4 → 0xF8000000. SRL with the same operands → 0x08000000. LUI b=0x1234 → 0x12340000.
- Signed multiply: MULT a=-3 b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. done exactly 34 edges after accept; ready low for 33 cycles; start pulses during busy are ignored.
- Divide: DIVU 100/7 → lo=14, hi=2. DIV -7/2 → lo=-3, hi=-1. DIV 0x80000000/-1 → lo=0x80000000, hi=0. DIV 5/0 → lo=0xFFFFFFFF, hi=5.
- Reset mid-operation: assert rst 10 cycles into DIVU. Outputs go to their reset values immediately (asynchronously), no done appears, and the next ADD 2+3 → 5 with latency 1.
- Back-to-back: ADD then MULTU 0xFFFFFFFF*2 issued on the edge ending the ADD's done cycle → hi=1, lo=0xFFFFFFFE. WIDTH=8 build: MULTU 0xFF*0xFF → hi=0xFE, lo=0x01, done after 10 edges.
